// File: rtl/axi_lite_reg_responder.sv
// AXI-Lite responder fronting a bank of NUM_REGS 32-bit configuration/status
// registers. Register 0 is a read-only ID word. The read and write channels run
// as independent FSMs, and each channel allows one outstanding transaction.
// Optional build macro REG_RESP_ERR_EN: when it is defined, an invalid access
// gets SLVERR and an invalid read returns 32'hDEAD_BEEF. When it is undefined,
// an invalid access gets OKAY and an invalid read returns zero.
module axi_lite_reg_responder #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 32'hBA02_0001
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   aw_addr,
  input  logic                    aw_valid,
  output logic                    aw_ready,
  input  logic [DATA_WIDTH-1:0]   w_data,
  input  logic [DATA_WIDTH/8-1:0] w_strb,
  input  logic                    w_valid,
  output logic                    w_ready,
  output logic [1:0]              b_resp,
  output logic                    b_valid,
  input  logic                    b_ready,
  input  logic [ADDR_WIDTH-1:0]   ar_addr,
  input  logic                    ar_valid,
  output logic                    ar_ready,
  output logic [DATA_WIDTH-1:0]   r_data,
  output logic [1:0]              r_resp,
  output logic                    r_valid,
  input  logic                    r_ready
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_WIDTH  = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1;
  localparam logic [1:0] RESP_OKAY = 2'b00;

`ifdef REG_RESP_ERR_EN
  localparam logic [1:0]            BAD_RESP = 2'b10;
  localparam logic [DATA_WIDTH-1:0] BAD_DATA = 32'hDEAD_BEEF;
`else
  localparam logic [1:0]            BAD_RESP = RESP_OKAY;
  localparam logic [DATA_WIDTH-1:0] BAD_DATA = '0;
`endif

  generate
    if (DATA_WIDTH != 32) begin : g_bad_data_width
      $error("axi_lite_reg_responder supports DATA_WIDTH=32 only");
    end
    if (NUM_REGS < 2) begin : g_bad_num_regs
      $error("axi_lite_reg_responder needs NUM_REGS >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} r_state_e;

  typedef struct packed {
    logic                 hit;
    logic [IDX_WIDTH-1:0] idx;
  } decode_t;

  // The address must be at or above the base, word aligned, and inside the bank.
  function automatic decode_t decode(input logic [ADDR_WIDTH-1:0] addr);
    decode_t                 res;
    logic [ADDR_WIDTH-1:0]   word;
    word    = (addr - BASE_ADDR) >> 2;
    res.hit = (addr >= BASE_ADDR) && (addr[1:0] == 2'b00) &&
              (word < ADDR_WIDTH'(NUM_REGS));
    res.idx = word[IDX_WIDTH-1:0];
    return res;
  endfunction

  // Each set strobe bit selects the matching new byte. A clear bit keeps the old byte.
  function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old_val,
                                                  input logic [DATA_WIDTH-1:0] new_val,
                                                  input logic [STRB_WIDTH-1:0] strb);
    logic [DATA_WIDTH-1:0] res;
    res = old_val;
    for (int b = 0; b < STRB_WIDTH; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  // Register 0 is the constant ID word, so only registers 1..N-1 are stored.
  logic [DATA_WIDTH-1:0] regs_q [1:NUM_REGS-1];
  logic [DATA_WIDTH-1:0] regs_d [1:NUM_REGS-1];

  logic [1:0]            b_resp_q, b_resp_d;
  logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
  logic [1:0]            r_resp_q, r_resp_d;
  decode_t               wr_dec, rd_dec;

  // ---------------- write channel ----------------

  // Write FSM state register.
  // NOTE: sequential state is updated with non-blocking assignments only. This
  // way every flop samples values from before the edge, whatever the order of
  // the always blocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) w_state_q <= W_IDLE;
    else        w_state_q <= w_state_d;
  end

  // Write FSM next state. The FSM accepts only when address and data arrive together.
  // NOTE: the next state gets a default before the case. Without it, a path
  // that leaves the next state unassigned would infer a latch.
  always_comb begin
    w_state_d = w_state_q;
    unique case (w_state_q)
      W_IDLE:  if (aw_valid && w_valid) w_state_d = W_ACK;
      W_ACK:   w_state_d = W_RESP;
      W_RESP:  if (b_ready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write channel outputs are decoded from the state flop.
  always_comb begin
    aw_ready = (w_state_q == W_ACK);
    w_ready  = (w_state_q == W_ACK);
    b_valid  = (w_state_q == W_RESP);
    b_resp   = b_resp_q;
  end

  // Commit on the handshake edge. Register 0 and invalid addresses are left unchanged.
  always_comb begin
    regs_d   = regs_q;
    b_resp_d = b_resp_q;
    wr_dec   = decode(aw_addr);
    if (w_state_q == W_ACK) begin
      if (wr_dec.hit) begin
        b_resp_d = RESP_OKAY;
        if (wr_dec.idx != '0) begin
          regs_d[wr_dec.idx] = merge(regs_q[wr_dec.idx], w_data, w_strb);
        end
      end else begin
        b_resp_d = BAD_RESP;
      end
    end
  end

  // Register bank storage and the held write response.
  // NOTE: the register bank is reset deliberately, because software expects
  // zeros after reset. A plain RAM-style array would normally be left without
  // a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NUM_REGS; i++) regs_q[i] <= '0;
      b_resp_q <= RESP_OKAY;
    end else begin
      regs_q   <= regs_d;
      b_resp_q <= b_resp_d;
    end
  end

  // ---------------- read channel ----------------

  // Read FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state_q <= R_IDLE;
    else        r_state_q <= r_state_d;
  end

  // Read FSM next state.
  always_comb begin
    r_state_d = r_state_q;
    unique case (r_state_q)
      R_IDLE:  if (ar_valid) r_state_d = R_ACK;
      R_ACK:   r_state_d = R_DATA;
      R_DATA:  if (r_ready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read channel outputs are decoded from the state flop.
  always_comb begin
    ar_ready = (r_state_q == R_ACK);
    r_valid  = (r_state_q == R_DATA);
    r_data   = r_data_q;
    r_resp   = r_resp_q;
  end

  // Sample read data on the handshake edge. Because regs_q still holds the
  // pre-write value, a same-edge write to the same register is not seen.
  always_comb begin
    r_data_d = r_data_q;
    r_resp_d = r_resp_q;
    rd_dec   = decode(ar_addr);
    if (r_state_q == R_ACK) begin
      if (!rd_dec.hit) begin
        r_data_d = BAD_DATA;
        r_resp_d = BAD_RESP;
      end else if (rd_dec.idx == '0) begin
        r_data_d = ID_VALUE;
        r_resp_d = RESP_OKAY;
      end else begin
        r_data_d = regs_q[rd_dec.idx];
        r_resp_d = RESP_OKAY;
      end
    end
  end

  // Held read data and read response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_q <= '0;
      r_resp_q <= RESP_OKAY;
    end else begin
      r_data_q <= r_data_d;
      r_resp_q <= r_resp_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_reg_responder.sv
// Directed testbench for axi_lite_reg_responder. Expected values are computed by hand.
module tb_axi_lite_reg_responder;

`ifdef REG_RESP_ERR_EN
  localparam logic [1:0]  BAD_RESP = 2'b10;
  localparam logic [31:0] BAD_DATA = 32'hDEAD_BEEF;
`else
  localparam logic [1:0]  BAD_RESP = 2'b00;
  localparam logic [31:0] BAD_DATA = 32'h0000_0000;
`endif
  localparam logic [31:0] ID = 32'hBA02_0001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] aw_addr, w_data, ar_addr, r_data;
  logic [3:0]  w_strb;
  logic        aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
  logic        ar_valid, ar_ready, r_valid, r_ready;
  logic [1:0]  b_resp, r_resp;

  int total = 0;
  int bad   = 0;

  logic [1:0]  resp;
  logic [31:0] data;

  axi_lite_reg_responder dut (
    .clk(clk), .rst_n(rst_n),
    .aw_addr(aw_addr), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
    .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
    .ar_addr(ar_addr), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_ready(r_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] rsp);
    int n;
    @(negedge clk);
    aw_addr = a; w_data = d; w_strb = s;
    aw_valid = 1'b1; w_valid = 1'b1; b_ready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!aw_ready && n < 20);
    if (!aw_ready) check("aw_ready_timeout", {31'b0, aw_ready}, 32'd1);
    @(negedge clk);
    aw_valid = 1'b0; w_valid = 1'b0;
    n = 0;
    while (!b_valid && n < 20) begin @(negedge clk); n++; end
    if (!b_valid) check("b_valid_timeout", {31'b0, b_valid}, 32'd1);
    rsp = b_resp;
    @(negedge clk);
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] rsp);
    int n;
    @(negedge clk);
    ar_addr = a; ar_valid = 1'b1; r_ready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!ar_ready && n < 20);
    if (!ar_ready) check("ar_ready_timeout", {31'b0, ar_ready}, 32'd1);
    @(negedge clk);
    ar_valid = 1'b0;
    n = 0;
    while (!r_valid && n < 20) begin @(negedge clk); n++; end
    if (!r_valid) check("r_valid_timeout", {31'b0, r_valid}, 32'd1);
    d = r_data; rsp = r_resp;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    aw_addr = '0; w_data = '0; w_strb = '0; aw_valid = 1'b0; w_valid = 1'b0;
    b_ready = 1'b0; ar_addr = '0; ar_valid = 1'b0; r_ready = 1'b0;
    #1;
    check("rst_ready", {29'b0, aw_ready, w_ready, ar_ready}, 32'd0);
    check("rst_valid", {30'b0, b_valid, r_valid}, 32'd0);
    check("rst_resp",  {28'b0, b_resp, r_resp}, 32'd0);
    check("rst_rdata", r_data, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Basic full-word write and read-back.
    axi_write(32'h4, 32'h1234_5678, 4'hF, resp);  check("wr4_resp", {30'b0, resp}, 32'd0);
    axi_read(32'h4, data, resp);                   check("rd4_data", data, 32'h1234_5678);
    check("rd4_resp", {30'b0, resp}, 32'd0);

    // A partial-strobe write replaces byte 1 only.
    axi_write(32'h8, 32'hFFFF_FFFF, 4'hF, resp);
    axi_write(32'h8, 32'h0000_AB00, 4'b0010, resp);
    axi_read(32'h8, data, resp);                   check("rd8_strb", data, 32'hFFFF_ABFF);

    // Register 0 is the read-only ID.
    axi_read(32'h0, data, resp);                   check("rd0_id", data, ID);
    axi_write(32'h0, 32'h0, 4'hF, resp);           check("wr0_resp", {30'b0, resp}, 32'd0);
    axi_read(32'h0, data, resp);                   check("rd0_id_after", data, ID);

    // The last register in the bank.
    axi_write(32'h3C, 32'hCAFE_0F0F, 4'hF, resp);  check("wr3c_resp", {30'b0, resp}, 32'd0);
    axi_read(32'h3C, data, resp);                  check("rd3c_data", data, 32'hCAFE_0F0F);

    // Out-of-range and misaligned accesses.
    axi_read(32'h40, data, resp);                  check("rd40_data", data, BAD_DATA);
    check("rd40_resp", {30'b0, resp}, {30'b0, BAD_RESP});
    axi_read(32'h6, data, resp);                   check("rd6_data", data, BAD_DATA);
    check("rd6_resp", {30'b0, resp}, {30'b0, BAD_RESP});
    axi_write(32'h40, 32'h5555_5555, 4'hF, resp);  check("wr40_resp", {30'b0, resp}, {30'b0, BAD_RESP});
    axi_write(32'h6, 32'hFFFF_FFFF, 4'hF, resp);   check("wr6_resp", {30'b0, resp}, {30'b0, BAD_RESP});
    axi_write(32'h4, 32'h0, 4'h0, resp);           check("wr4_nostrb_resp", {30'b0, resp}, 32'd0);
    axi_read(32'h4, data, resp);                   check("rd4_unchanged", data, 32'h1234_5678);

    // A lone address or a lone data valid is never accepted.
    @(negedge clk); aw_addr = 32'h4; aw_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); check("lone_aw", {30'b0, aw_ready, w_ready}, 32'd0);
    end
    aw_valid = 1'b0; w_data = 32'h0; w_strb = 4'hF; w_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); check("lone_w", {30'b0, aw_ready, w_ready}, 32'd0);
    end
    w_valid = 1'b0;

    // Read and write of the same register committed on the same edge.
    axi_write(32'hC, 32'h1111_1111, 4'hF, resp);
    @(negedge clk);
    aw_addr = 32'hC; w_data = 32'h2222_2222; w_strb = 4'hF; aw_valid = 1'b1; w_valid = 1'b1;
    ar_addr = 32'hC; ar_valid = 1'b1; b_ready = 1'b1; r_ready = 1'b1;
    @(negedge clk); check("same_ready_lat1", {29'b0, aw_ready, w_ready, ar_ready}, 32'd7);
    @(negedge clk);
    aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
    check("same_valid_lat2", {30'b0, b_valid, r_valid}, 32'd3);
    check("same_pre_write", r_data, 32'h1111_1111);
    @(negedge clk); check("same_valid_drop", {30'b0, b_valid, r_valid}, 32'd0);
    axi_read(32'hC, data, resp);                   check("rdc_post_write", data, 32'h2222_2222);

    // A stalled write response while a read completes on the other channel.
    @(negedge clk);
    b_ready = 1'b0; aw_addr = 32'h10; w_data = 32'hA5A5_A5A5; w_strb = 4'hF;
    aw_valid = 1'b1; w_valid = 1'b1;
    @(negedge clk); check("hold_aw_ready", {31'b0, aw_ready}, 32'd1);
    @(negedge clk); aw_valid = 1'b0; w_valid = 1'b0;
    check("hold_bvalid_start", {31'b0, b_valid}, 32'd1);
    axi_read(32'h4, data, resp);                   check("hold_concurrent_rd", data, 32'h1234_5678);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); check("hold_b_stable", {29'b0, b_valid, b_resp}, 32'h4);
    end
    b_ready = 1'b1;
    @(negedge clk); check("hold_b_release", {31'b0, b_valid}, 32'd0);
    axi_read(32'h10, data, resp);                  check("rd10_data", data, 32'hA5A5_A5A5);

    // Reset while in R_DATA aborts the read and clears the bank.
    @(negedge clk); r_ready = 1'b0; ar_addr = 32'h4; ar_valid = 1'b1;
    @(negedge clk); check("rst_ar_ready", {31'b0, ar_ready}, 32'd1);
    @(negedge clk); ar_valid = 1'b0;
    check("rst_rvalid_before", {31'b0, r_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check("rst_rvalid_drop", {31'b0, r_valid}, 32'd0);
    check("rst_rdata_clear", r_data, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    axi_read(32'h4, data, resp);                   check("rd4_after_rst", data, 32'h0);
    axi_read(32'h0, data, resp);                   check("rd0_after_rst", data, ID);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog, in case a handshake never resolves.
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
